// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // SCLK must be no faster than clk / MIN_SCLK_DIV so every SCLK phase
    // spans enough system clocks to survive synchronization and edge detection.
    localparam int MIN_SCLK_DIV = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-bit flop-chain synchronizer for independent slow asynchronous inputs.
// Latency: STAGES clk cycles from din to dout.
// Backpressure: none; samples every cycle.
module bit_synchronizer #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain, preset to the idle level so reset release creates no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: shifts a preloaded word out on MISO, captures the MOSI word, MSB first.
// Latency: SS_n fall -> MISO valid within SYNC_STAGES+2 clk; rx_valid 1 clk after last sampled rise.
// Backpressure: tx_ready low while the holding register is full; it empties at the next frame start.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_WORD  = '0
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);

    logic [2:0]    sync_out;
    logic          sclk_s, ss_n_s, mosi_s;
    logic          sclk_d, ss_n_d;
    logic          ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [DW-1:0] hold_dat, last_tx, next_word;
    logic          hold_full, load_frame;
    logic [DW-1:0] shift_tx, shift_rx, rx_next;
    logic [CW-1:0] bit_cnt;
    state_t        state;

    // Order {sclk, ss_n, mosi}; idle preset is sclk=0, ss_n=1
    bit_synchronizer #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (3'b010)
    ) u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .din   ({spi_sclk, spi_ss_n, spi_mosi}),
        .dout  (sync_out)
    );

    assign {sclk_s, ss_n_s, mosi_s} = sync_out;

    // One-cycle delayed copies of the synchronized lines for edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_d <= 1'b0;
            ss_n_d <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            ss_n_d <= ss_n_s;
        end
    end

    assign ss_fall   =  ss_n_d & ~ss_n_s;
    assign ss_rise   = ~ss_n_d &  ss_n_s;
    assign sclk_rise = ~sclk_d &  sclk_s;
    assign sclk_fall =  sclk_d & ~sclk_s;

    assign load_frame = (state == ST_IDLE) && ss_fall;
    assign next_word  = hold_full ? hold_dat : last_tx;
    assign tx_ready   = ~hold_full;
    assign rx_next    = (shift_rx << 1) | {{(DW-1){1'b0}}, mosi_s};

    // Holding register: filled on valid&ready, emptied when a frame starts
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_dat  <= '0;
            hold_full <= 1'b0;
        end else if (load_frame) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_dat  <= tx_data;
            hold_full <= 1'b1;
        end
    end

    // Frame FSM with shifters, bit counter and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= ST_IDLE;
            shift_tx    <= '0;
            shift_rx    <= '0;
            bit_cnt     <= '0;
            last_tx     <= RESET_WORD;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        shift_tx    <= next_word;
                        last_tx     <= next_word;
                        spi_miso    <= next_word[DW-1];
                        spi_miso_oe <= 1'b1;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        // Sample first; a coincident ss_rise still counts this bit
                        shift_rx <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            if (ss_rise) begin
                                spi_miso    <= 1'b0;
                                spi_miso_oe <= 1'b0;
                                busy        <= 1'b0;
                                state       <= ST_IDLE;
                            end else begin
                                state <= ST_DONE;
                            end
                        end else if (ss_rise) begin
                            frame_err   <= 1'b1;
                            spi_miso    <= 1'b0;
                            spi_miso_oe <= 1'b0;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end else if (ss_rise) begin
                        frame_err   <= 1'b1;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (sclk_fall && (bit_cnt < CNT_FULL)) begin
                        shift_tx <= shift_tx << 1;
                        spi_miso <= shift_tx[DW-2];
                    end
                end
                ST_DONE: begin
                    // MISO holds the last bit; further SCLK activity is ignored
                    if (ss_rise) begin
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed + randomized bench for spi_slave_responder acting as a mode-0 SPI master at clk/8.
// Latency: master waits SYNC_STAGES+2 clk after SS_n fall before checking MISO.
// Backpressure: loads are issued only while the holding register is empty.
module tb_spi_slave_responder;

    localparam int          DW   = 16;
    localparam int          SS   = 2;
    localparam logic [15:0] RW   = 16'h0000;
    localparam int          HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid, frame_err, busy;

    int checks = 0;
    int errors = 0;

    // Monitor counters / captured rx words
    int          rxv_cnt = 0;
    int          fe_cnt  = 0;
    logic [15:0] rxq[$];

    // Reference model of the responder's observable state
    logic        m_hold_full;
    logic [15:0] m_hold, m_last, m_rx;

    spi_slave_responder #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS),
        .RESET_WORD  (RW)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .spi_sclk      (sclk),
        .spi_ss_n      (ss_n),
        .spi_mosi      (mosi),
        .spi_miso      (miso),
        .spi_miso_oe   (miso_oe),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rxq.push_back(rx_data);
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_hold_full = 1'b0;
        m_hold      = '0;
        m_last      = RW;
        m_rx        = '0;
    endtask

    task automatic load(input logic [15:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (!m_hold_full) begin
            m_hold_full = 1'b1;
            m_hold      = w;
        end
    endtask

    // Start a frame: returns the word the model says should appear on MISO
    task automatic start_frame(output logic [15:0] exp_tx);
        exp_tx      = m_hold_full ? m_hold : m_last;
        m_hold_full = 1'b0;
        m_last      = exp_tx;
        ss_n = 1'b0;
        wait_clk(SS + 2);
        check("oe_after_ss_fall", {31'd0, miso_oe}, 32'd1);
        check("busy_after_ss_fall", {31'd0, busy}, 32'd1);
        check("miso_msb_latency", {31'd0, miso}, {31'd0, exp_tx[15]});
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(HALF);
        m    = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    // Complete (n=16) or truncated frame with full checking against the model
    task automatic do_frame(input logic [15:0] mo, input int n, input int gap);
        logic [15:0] exp_tx, got, mask;
        logic        b;
        int          rx0, fe0;
        rx0 = rxv_cnt;
        fe0 = fe_cnt;
        got = '0;
        start_frame(exp_tx);
        for (int i = 0; i < n; i++) begin
            xfer_bit(mo[15-i], b);
            got = {got[14:0], b};
        end
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(gap);
        mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
        if (n >= 16) m_rx = mo;
        check("miso_word", {16'd0, got & mask}, {16'd0, 16'(exp_tx >> (16 - n)) & mask});
        check("rx_valid_pulses", rxv_cnt - rx0, (n >= 16) ? 1 : 0);
        check("frame_err_pulses", fe_cnt - fe0, (n >= 16) ? 0 : 1);
        check("rx_data", {16'd0, rx_data}, {16'd0, m_rx});
        check("idle_oe", {31'd0, miso_oe}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int          n;
        model_reset();

        // Reset values
        wait_clk(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {16'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // No load since reset: RESET_WORD, then repeated
        do_frame(16'h0F0F, 16, 4);
        do_frame(16'h8001, 16, 4);

        // Basic load and exchange, then repeat of last sent word
        load(16'hA5C3);
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
        do_frame(16'h1234, 16, 4);
        check("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);
        do_frame(16'h5A5A, 16, 4);

        // Truncated frame after 7 bits, then a clean frame
        load(16'h3C96);
        do_frame(16'hFFFF, 7, 4);
        load(16'h7E81);
        do_frame(16'hC0DE, 16, 4);

        // tx load during a frame only affects the next frame
        load(16'h1111);
        fork
            do_frame(16'h2468, 16, 4);
            begin
                wait_clk(50);
                load(16'hBEEF);
                check("tx_ready_mid_frame", {31'd0, tx_ready}, 32'd0);
            end
        join
        check("tx_ready_held", {31'd0, tx_ready}, 32'd0);
        do_frame(16'h1357, 16, 4);
        check("tx_ready_consumed", {31'd0, tx_ready}, 32'd1);

        // Reset pulse mid-frame
        load(16'h4242);
        begin
            logic [15:0] e;
            logic        b;
            int          fe0;
            fe0 = fe_cnt;
            start_frame(e);
            for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
            rst_n = 1'b0;
            ss_n  = 1'b1;
            sclk  = 1'b0;
            wait_clk(2);
            model_reset();
            check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
            check("mid_rst_miso", {31'd0, miso}, 32'd0);
            check("mid_rst_busy", {31'd0, busy}, 32'd0);
            check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
            check("mid_rst_rx_data", {16'd0, rx_data}, 32'd0);
            rst_n = 1'b1;
            wait_clk(6);
            check("mid_rst_no_frame_err", fe_cnt - fe0, 0);
        end
        load(16'h9ABC);
        do_frame(16'hDEF0, 16, 4);

        // Back-to-back frames with SS_n high for 4 clk
        load(16'h6C6C);
        rxq.delete();
        do_frame(16'hAAAA, 16, 4);
        do_frame(16'h5555, 16, 4);
        check("b2b_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            check("b2b_first", {16'd0, rxq[0]}, 32'h0000AAAA);
            check("b2b_second", {16'd0, rxq[1]}, 32'h00005555);
        end

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            w = 16'($urandom);
            do_frame(w, n, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
